// File: rtl/vend_pkg.sv
// Shared vending definitions: dispense sequencer states, change encoding used
// by the vending FSM's change output, and default actuator timing.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VEND,
    ST_COIN_FIRE,
    ST_COIN_WAIT,
    ST_DONE,
    ST_FAULT
  } state_t;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_15   = 2'b11;

  localparam int PULSE_CYC_DEF   = 4;
  localparam int TIMEOUT_CYC_DEF = 16;

  // Counter width able to hold the larger of the two reload values (max-1).
  function automatic int timer_w(input int p, input int t);
    int m;
    m = (p > t) ? p : t;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; zero is high once the count has run out and stays
// high until the next load.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/change_dispense_ctrl.sv
// Bottle/change actuator sequencer: one request at a time, fixed-width drive
// pulses, sensor-confirmed coins with timeout. CHANGE_RETRY_EN adds one
// re-fire per coin before declaring a hopper fault.
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int PULSE_CYC   = PULSE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_vend,
  input  logic [1:0] req_amt,
  output logic       req_ready,
  output logic       vend_fire,
  output logic       hopper_fire,
  input  logic       hopper_sense,
  output logic       done,
  output logic       fault,
  input  logic       fault_clr,
  output logic [1:0] coins_left
);

  localparam int TW = timer_w(PULSE_CYC, TIMEOUT_CYC);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] TO_LD    = TW'(TIMEOUT_CYC - 1);

  state_t     state_q, state_d;
  logic [1:0] coins_q, coins_d;
  logic       sense_q;
  logic       pend_q, pend_d;
  logic       req_ready_q, req_ready_d;
  logic       vend_fire_q, vend_fire_d;
  logic       hopper_fire_q, hopper_fire_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;
`ifdef CHANGE_RETRY_EN
  logic       retry_q, retry_d;
`endif

  logic       accept, sense_rise, coin_evt, t_load, t_zero;
  logic [TW-1:0] t_val;

  assign accept     = req_valid && req_ready_q;
  assign sense_rise = hopper_sense && !sense_q;
  // A rise seen while still firing is held and credited on the first wait cycle.
  assign coin_evt   = (state_q == ST_COIN_WAIT) && (sense_rise || pend_q);

  // One timer serves drive pulses and the coin timeout; reload on state entry.
  assign t_load = (state_d != state_q) &&
                  (state_d == ST_VEND || state_d == ST_COIN_FIRE || state_d == ST_COIN_WAIT);
  assign t_val  = (state_d == ST_COIN_WAIT) ? TO_LD : PULSE_LD;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_vend)                 state_d = ST_VEND;
          else if (req_amt != CHG_NONE) state_d = ST_COIN_FIRE;
          else                          state_d = ST_DONE;
        end
      end
      ST_VEND: begin
        if (t_zero) state_d = (coins_q != CHG_NONE) ? ST_COIN_FIRE : ST_DONE;
      end
      ST_COIN_FIRE: begin
        if (t_zero) state_d = ST_COIN_WAIT;
      end
      ST_COIN_WAIT: begin
        if (coin_evt)    state_d = (coins_q == 2'd1) ? ST_DONE : ST_COIN_FIRE;
`ifdef CHANGE_RETRY_EN
        else if (t_zero) state_d = retry_q ? ST_FAULT : ST_COIN_FIRE;
`else
        else if (t_zero) state_d = ST_FAULT;
`endif
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: if (fault_clr) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    coins_d = coins_q;
    if (state_q == ST_IDLE && accept)         coins_d = req_amt;
    else if (coin_evt)                        coins_d = coins_q - 2'd1;
    else if (state_q == ST_FAULT && fault_clr) coins_d = 2'd0;
    pend_d = (state_q == ST_COIN_FIRE) ? (pend_q || sense_rise) : 1'b0;
`ifdef CHANGE_RETRY_EN
    retry_d = retry_q;
    if (accept || coin_evt)                   retry_d = 1'b0;
    else if (state_q == ST_COIN_WAIT && t_zero) retry_d = 1'b1;
`endif
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    req_ready_d   = (state_d == ST_IDLE);
    vend_fire_d   = (state_d == ST_VEND);
    hopper_fire_d = (state_d == ST_COIN_FIRE);
    done_d        = (state_d == ST_DONE);
    fault_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      coins_q       <= 2'd0;
      sense_q       <= 1'b0;
      pend_q        <= 1'b0;
      req_ready_q   <= 1'b0;
      vend_fire_q   <= 1'b0;
      hopper_fire_q <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
`ifdef CHANGE_RETRY_EN
      retry_q       <= 1'b0;
`endif
    end else begin
      coins_q       <= coins_d;
      sense_q       <= hopper_sense;
      pend_q        <= pend_d;
      req_ready_q   <= req_ready_d;
      vend_fire_q   <= vend_fire_d;
      hopper_fire_q <= hopper_fire_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
`ifdef CHANGE_RETRY_EN
      retry_q       <= retry_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign vend_fire   = vend_fire_q;
  assign hopper_fire = hopper_fire_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign coins_left  = coins_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Scoreboard bench for change_dispense_ctrl: directed and random requests,
// a reactive hopper sensor model, and a monitor comparing each request's outcome.
module tb_change_dispense_ctrl;

  localparam int P = 4;
  localparam int T = 16;
`ifdef CHANGE_RETRY_EN
  localparam int ATT = 2;
`else
  localparam int ATT = 1;
`endif
  localparam int SILENT = -1;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_vend;
  logic [1:0] req_amt;
  logic       req_ready;
  logic       vend_fire;
  logic       hopper_fire;
  logic       hopper_sense = 1'b0;
  logic       done;
  logic       fault;
  logic       fault_clr;
  logic [1:0] coins_left;

  change_dispense_ctrl #(.PULSE_CYC(P), .TIMEOUT_CYC(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_vend     (req_vend),
    .req_amt      (req_amt),
    .req_ready    (req_ready),
    .vend_fire    (vend_fire),
    .hopper_fire  (hopper_fire),
    .hopper_sense (hopper_sense),
    .done         (done),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .coins_left   (coins_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int amt;
    int vcyc;
    int hp;
    int fault;
    int left;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   issued = 0;
  int   ncomp = 0;

  // Outcome from the request rules: each coin costs a pulse, its sensor delay
  // and one detect cycle; a silent coin costs pulse+timeout per attempt.
  function automatic exp_t model(input int v, input int amt, input int d0, input int d1, input int d2);
    exp_t e;
    int d[3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    e.amt = amt; e.vcyc = v ? P : 0; e.hp = 0; e.fault = 0; e.left = amt;
    e.lat = 1 + e.vcyc;
    for (int i = 0; i < amt; i++) begin
      if (d[i] < 0) begin
        e.hp += ATT; e.lat += ATT * (P + T); e.fault = 1;
        break;
      end
      e.hp++; e.lat += P + d[i] + 1; e.left--;
    end
    return e;
  endfunction

  // Sensor plan, owned by the driver.
  int plan_d[3] = '{SILENT, SILENT, SILENT};
  int plan_len = 1;
  int gen = 0;

  // Reactive sensor: after each hopper pulse ends, raise sense after the
  // planned delay for plan_len cycles, or stay silent.
  int seen_gen = 0, idx = 0, wcnt = 0, hcnt = 0;
  bit armed = 1'b0, hf_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      armed = 1'b0; hcnt = 0; hopper_sense = 1'b0;
    end
    if (gen != seen_gen) begin seen_gen = gen; idx = 0; armed = 1'b0; end
    if (hf_prev && !hopper_fire && idx < 3) begin
      if (plan_d[idx] >= 0) begin wcnt = plan_d[idx]; armed = 1'b1; idx++; end
    end
    hf_prev = hopper_fire;
    if (armed) begin
      if (wcnt == 0) begin hopper_sense = 1'b1; hcnt = plan_len; armed = 1'b0; end
      else wcnt--;
    end else if (hcnt > 0) begin
      hcnt--;
      if (hcnt == 0) hopper_sense = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  exp_t cur;
  bit   active = 1'b0, hf_p = 1'b0, post_done = 1'b0, clr_chk = 1'b0;
  int   c = 0, vc = 0, hp = 0, run = 0, rst_ph = 0;
  always @(negedge clk) begin
    if (rst_ph == 1) begin
      chk("reset_outputs_zero", int'({req_ready, vend_fire, hopper_fire, done, fault, coins_left}), 0);
      rst_ph = rst ? 1 : 2;
    end else if (rst_ph == 2) begin
      chk("ready_after_reset", int'(req_ready), 1);
      rst_ph = 0;
    end
    if (rst) begin
      if (active) begin active = 1'b0; ncomp++; end
      sb.delete();
      rst_ph = 1; post_done = 1'b0; clr_chk = 1'b0;
    end else begin
      if (post_done) begin chk("ready_after_done", int'(req_ready), 1); post_done = 1'b0; end
      if (clr_chk) begin
        chk("fault_clr_ready", int'(req_ready), 1);
        chk("fault_clr_coins", int'(coins_left), 0);
        chk("fault_clr_fault", int'(fault), 0);
        clr_chk = 1'b0;
      end
      if (active) begin
        c++;
        if (c == 1) chk("coins_latched", int'(coins_left), cur.amt);
        if (vend_fire) vc++;
        if (hopper_fire) begin
          if (!hf_p) hp++;
          run++;
        end else if (hf_p) begin
          chk("hopper_pulse_width", run, P);
          run = 0;
        end
        hf_p = hopper_fire;
        if (done || fault) begin
          chk("fault_flag", int'(fault), cur.fault);
          chk("done_flag", int'(done), 1 - cur.fault);
          chk("latency", c, cur.lat);
          chk("vend_cycles", vc, cur.vcyc);
          chk("hopper_pulses", hp, cur.hp);
          chk("coins_left_end", int'(coins_left), cur.left);
          post_done = done;
          active = 1'b0; ncomp++;
        end else if (c > 600) begin
          chk("request_completes", 0, 1);
          active = 1'b0; ncomp++;
        end
      end else if (done) begin
        chk("unexpected_done", 1, 0);
      end
      if (fault && fault_clr) clr_chk = 1'b1;
      if (req_valid && req_ready) begin
        if (sb.size() == 0) chk("scoreboard_nonempty", 0, 1);
        else begin
          cur = sb.pop_front();
          active = 1'b1; c = 0; vc = 0; hp = 0; run = 0; hf_p = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(req_ready && !hopper_sense && !armed && hcnt == 0)) begin
      step(); n++;
      if (n > 1000) begin
        $display("[TB] FAIL wait_idle: req_ready stuck at %0d, expected 1", req_ready);
        $fatal(1, "bench stalled");
      end
    end
  endtask

  task automatic issue(input int v, input int amt, input int d0, input int d1, input int d2,
                       input int len, input bit wait_cpl);
    int n = 0;
    wait_idle();
    plan_d[0] = d0; plan_d[1] = d1; plan_d[2] = d2; plan_len = len; gen++;
    sb.push_back(model(v, amt, d0, d1, d2));
    issued++;
    req_valid = 1'b1; req_vend = v[0]; req_amt = amt[1:0];
    step();
    req_valid = 1'b0; req_vend = 1'b0; req_amt = 2'd0;
    if (!wait_cpl) return;
    while (ncomp != issued) begin
      step(); n++;
      if (n > 1000) begin
        $display("[TB] FAIL completion: got %0d completions, expected %0d", ncomp, issued);
        $fatal(1, "bench stalled");
      end
    end
    step();
    if (fault) begin
      fault_clr = 1'b1; step(); fault_clr = 1'b0; step();
    end
  endtask

  initial begin
    int v, amt, d[3], len, n;
    rst = 1'b1; req_valid = 1'b0; req_vend = 1'b0; req_amt = 2'd0; fault_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step(); step();

    issue(1, 0, SILENT, SILENT, SILENT, 1, 1);        // bottle only
    issue(1, 2, 2, 2, SILENT, 2, 1);                   // bottle + 10 rs
    issue(0, 1, 1, SILENT, SILENT, 10, 1);             // held sensor counts once
    issue(0, 3, 1, 3, SILENT, 1, 1);                   // third coin never sensed
    issue(0, 1, T - 1, SILENT, SILENT, 1, 1);          // edge on expiry cycle
    issue(0, 0, SILENT, SILENT, SILENT, 1, 1);         // empty request
    issue(1, 3, 0, 0, 0, P, 1);

    // Reset in the middle of a hopper pulse.
    issue(0, 2, SILENT, SILENT, SILENT, 1, 0);
    n = 0;
    while (!hopper_fire && n < 50) begin step(); n++; end
    step();
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    issue(0, 2, 1, 0, SILENT, 1, 1);

    for (int k = 0; k < 40; k++) begin
      v = int'($urandom_range(0, 1));
      amt = int'($urandom_range(0, 3));
      for (int i = 0; i < 3; i++)
        d[i] = ($urandom_range(0, 7) == 0) ? SILENT : int'($urandom_range(0, T - 1));
      len = int'($urandom_range(1, P));
      if ($urandom_range(0, 3) == 0) begin
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
      end
      issue(v, amt, d[0], d[1], d[2], len, 1);
    end

    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
